// File: rtl/bus_slave_mem.sv
// Memory-backed req/ack bus responder: one request at a time, WAIT_CYCLES wait
// states, one-cycle registered ack, read data on the cycle after the ack.
module bus_slave_mem #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slave_req,
    input  logic [31:0] slave_addr,
    input  logic        slave_cmd,
    input  logic [31:0] slave_wdata,
    output logic        slave_ack,
    output logic [31:0] slave_rdata
);

    localparam int         DEPTH   = 1 << AW;
    localparam logic [7:0] WAIT_LD = 8'(WAIT_CYCLES);
    localparam logic       CMD_WR  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_RDATA
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            cmd_q, cmd_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mem_we;
    logic [31:0]     mem [0:DEPTH-1];

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic addr_unused;
    assign addr_unused = ^{slave_addr[31:AW+2], slave_addr[1:0]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            cmd_q   <= 1'b0;
            wdata_q <= 32'd0;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (slave_req) begin
                    state_d = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 8'd1) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = (cmd_q == CMD_WR) ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath / outputs; the payload is only sampled in IDLE.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slave_req) begin
                    idx_d   = slave_addr[AW+1:2];
                    cmd_d   = slave_cmd;
                    wdata_d = slave_wdata;
                    cnt_d   = WAIT_LD;
                end
            end
            ST_WAIT: begin
                cnt_d = (cnt_q <= 8'd1) ? 8'd0 : cnt_q - 8'd1;
            end
            ST_ACK: begin
                if (cmd_q == CMD_WR) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d = mem[idx_q];
                end
            end
            default: begin
            end
        endcase
        // Registered ack: asserted during exactly the cycle spent in ACK.
        ack_d = (state_d == ST_ACK);
    end

    // Storage is not reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign slave_ack   = ack_q;
    assign slave_rdata = rdata_q;

endmodule

// File: tb/tb_bus_slave_mem.sv
// Directed bench for bus_slave_mem: one instance with 2 wait states, one with 0.
module tb_bus_slave_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req0;
    logic        cmd;
    logic [31:0] addr, wdata;
    logic        ack, ack0;
    logic [31:0] rdata, rdata0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    bus_slave_mem #(.AW(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .slave_req(req), .slave_addr(addr),
        .slave_cmd(cmd), .slave_wdata(wdata), .slave_ack(ack), .slave_rdata(rdata)
    );

    bus_slave_mem #(.AW(10), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .slave_req(req0), .slave_addr(addr),
        .slave_cmd(cmd), .slave_wdata(wdata), .slave_ack(ack0), .slave_rdata(rdata0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction starting in the current cycle (cycle 0). Scrambles the
    // payload during WAIT, drops req on ack, returns first ack cycle, ack count and
    // the rdata seen the cycle after the ack. Bounded to 8 cycles.
    task automatic run_txn(input bit use0, input bit c, input logic [31:0] a,
                           input logic [31:0] d, output int ack_cyc,
                           output int ack_cnt, output logic [31:0] rd);
        ack_cyc = -1;
        ack_cnt = 0;
        rd      = 32'hxxxx_xxxx;
        addr = a; cmd = c; wdata = d;
        if (use0) req0 = 1'b1; else req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (ack_cyc >= 0 && i == ack_cyc + 1) rd = use0 ? rdata0 : rdata;
            if (use0 ? ack0 : ack) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = i;
                req = 1'b0; req0 = 1'b0;
                addr = 32'h0000_03FC; wdata = 32'h0BAD_0BAD; cmd = ~c;
            end else if (i == 1) begin
                addr = a ^ 32'h0000_0040; wdata = ~d; cmd = ~c;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; req0 = 1'b0; cmd = 1'b0; addr = 32'd0; wdata = 32'd0;
        tick(); tick();
        n_checks++; if (ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", ack); else n_pass++;
        n_checks++; if (rdata !== 32'd0) $display("FAIL rst_rdata: got %h want 0", rdata); else n_pass++;
        n_checks++; if (ack0 !== 1'b0) $display("FAIL rst_ack0: got %b want 0", ack0); else n_pass++;
        n_checks++; if (rdata0 !== 32'd0) $display("FAIL rst_rdata0: got %h want 0", rdata0); else n_pass++;
        #3 rst_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_write();
        int ac, cnt; logic [31:0] rd;
        run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, ac, cnt, rd);
        n_checks++; if (ac !== 3) $display("FAIL wr_ack_cycle: got %0d want 3", ac); else n_pass++;
        n_checks++; if (cnt !== 1) $display("FAIL wr_ack_count: got %0d want 1", cnt); else n_pass++;
        n_checks++; if (rdata !== 32'd0) $display("FAIL wr_rdata_untouched: got %h want 0", rdata); else n_pass++;
    endtask

    task automatic test_read();
        int ac, cnt; logic [31:0] rd;
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, ac, cnt, rd);
        n_checks++; if (ac !== 3) $display("FAIL rd_ack_cycle: got %0d want 3", ac); else n_pass++;
        n_checks++; if (cnt !== 1) $display("FAIL rd_ack_count: got %0d want 1", cnt); else n_pass++;
        n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", rd); else n_pass++;
        n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL rd_hold: got %h want deadbeef", rdata); else n_pass++;
        run_txn(1'b0, 1'b1, 32'h0000_0014, 32'h1234_5678, ac, cnt, rd);
        n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL rd_hold_after_wr: got %h want deadbeef", rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int a1 = -1, a2 = -1, cnt = 0;
        logic [31:0] rd = 32'hxxxx_xxxx;
        addr = 32'h4; cmd = 1'b1; wdata = 32'h1111_1111; req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (a2 >= 0 && i == a2 + 1) rd = rdata;
            if (ack) begin
                cnt++;
                if (a1 < 0) begin
                    a1 = i; cmd = 1'b0; addr = 32'h4; wdata = 32'h0;
                end else if (a2 < 0) begin
                    a2 = i; req = 1'b0;
                end
            end
        end
        req = 1'b0;
        n_checks++; if (a1 !== 3) $display("FAIL b2b_ack1: got %0d want 3", a1); else n_pass++;
        n_checks++; if (a2 !== 7) $display("FAIL b2b_ack2: got %0d want 7", a2); else n_pass++;
        n_checks++; if (cnt !== 2) $display("FAIL b2b_ack_count: got %0d want 2", cnt); else n_pass++;
        n_checks++; if (rd !== 32'h1111_1111) $display("FAIL b2b_rdata: got %h want 11111111", rd); else n_pass++;
    endtask

    task automatic test_zero_wait();
        int ac, cnt; logic [31:0] rd;
        int a1 = -1, a2 = -1;
        logic [31:0] rd1 = 32'hxxxx_xxxx, rd2 = 32'hxxxx_xxxx;
        run_txn(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_0000, ac, cnt, rd);
        n_checks++; if (ac !== 1) $display("FAIL w0_wr_ack_cycle: got %0d want 1", ac); else n_pass++;
        run_txn(1'b1, 1'b1, 32'h0000_0024, 32'h0000_BEEF, ac, cnt, rd);
        n_checks++; if (cnt !== 1) $display("FAIL w0_wr_ack_count: got %0d want 1", cnt); else n_pass++;
        addr = 32'h20; cmd = 1'b0; req0 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (a1 >= 0 && i == a1 + 1) rd1 = rdata0;
            if (a2 >= 0 && i == a2 + 1) rd2 = rdata0;
            if (ack0) begin
                if (a1 < 0) begin
                    a1 = i; addr = 32'h24;
                end else if (a2 < 0) begin
                    a2 = i; req0 = 1'b0;
                end
            end
        end
        req0 = 1'b0;
        n_checks++; if (a1 !== 1) $display("FAIL w0_rd_ack1: got %0d want 1", a1); else n_pass++;
        n_checks++; if (rd1 !== 32'hCAFE_0000) $display("FAIL w0_rd_data1: got %h want cafe0000", rd1); else n_pass++;
        n_checks++; if (a2 !== 4) $display("FAIL w0_rd_ack2: got %0d want 4", a2); else n_pass++;
        n_checks++; if (rd2 !== 32'h0000_BEEF) $display("FAIL w0_rd_data2: got %h want 0000beef", rd2); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int ac, cnt, acks; logic [31:0] rd;
        run_txn(1'b0, 1'b1, 32'h0000_0008, 32'h0000_0005, ac, cnt, rd);
        addr = 32'h8; cmd = 1'b1; wdata = 32'h0000_0999; req = 1'b1;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (rdata !== 32'd0) $display("FAIL abort_rdata: got %h want 0", rdata); else n_pass++;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack) acks++;
        end
        req = 1'b0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ack) acks++;
        end
        n_checks++; if (acks !== 0) $display("FAIL abort_no_ack: got %0d acks want 0", acks); else n_pass++;
        run_txn(1'b0, 1'b0, 32'h0000_0008, 32'h0, ac, cnt, rd);
        n_checks++; if (rd !== 32'h0000_0005) $display("FAIL abort_mem_kept: got %h want 00000005", rd); else n_pass++;
    endtask

    task automatic test_alias();
        int ac, cnt; logic [31:0] rd;
        run_txn(1'b0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, ac, cnt, rd);
        run_txn(1'b0, 1'b0, 32'h8000_0004, 32'h0, ac, cnt, rd);
        n_checks++; if (rd !== 32'hA5A5_A5A5) $display("FAIL alias_hi_bits: got %h want a5a5a5a5", rd); else n_pass++;
        run_txn(1'b0, 1'b0, 32'h0000_0007, 32'h0, ac, cnt, rd);
        n_checks++; if (rd !== 32'hA5A5_A5A5) $display("FAIL alias_byte_off: got %h want a5a5a5a5", rd); else n_pass++;
        run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, ac, cnt, rd);
        n_checks++; if (rd !== 32'hDEAD_BEEF) $display("FAIL alias_other_word: got %h want deadbeef", rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_zero_wait();
        test_reset_abort();
        test_alias();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
